// File: rtl/clint_pkg.sv
// CLINT shared definitions: register offsets, bus request/response structs
// and the byte-lane merge helper used by every writable register.
`default_nettype none

package clint_pkg;

   localparam logic [15:0] clint_msip      = 16'h0000;
   localparam logic [15:0] clint_mtimecmp  = 16'h4000;
   localparam logic [15:0] clint_mtimecmph = 16'h4004;
   localparam logic [15:0] clint_mtime     = 16'hBFF8;
   localparam logic [15:0] clint_mtimeh    = 16'hBFFC;

   typedef struct packed {
      logic        valid;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } clint_in_type;

   typedef struct packed {
      logic [31:0] rdata;
      logic        ready;
   } clint_out_type;

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  wstrb);
      logic [31:0] res;
      res = old_val;
      for (int i = 0; i < 4; i++) begin
         if (wstrb[i]) res[8*i +: 8] = wdata[8*i +: 8];
      end
      return res;
   endfunction

endpackage

`default_nettype wire

// File: rtl/clint_tick.sv
// CLINT real-time prescaler: counts 0..RTC_DIV-1 and pulses tick on the wrap.
`default_nettype none

module clint_tick #(
   parameter int RTC_DIV = 50
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam logic [15:0] LAST = 16'(RTC_DIV - 1);

   logic [15:0] count;

   // With RTC_DIV=1 the count never leaves 0, so tick is permanently high.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (count == LAST) begin
         count <= '0;
      end else begin
         count <= count + 16'd1;
      end
   end

   assign tick = (count == LAST);

endmodule

`default_nettype wire

// File: rtl/clint.sv
// CLINT: memory-mapped msip, mtime and mtimecmp with timer/software interrupts.
`default_nettype none

module clint
   import clint_pkg::*;
#(
   parameter int RTC_DIV = 50
) (
   input  logic          clk,
   input  logic          rst,
   input  clint_in_type  clint_in,
   output clint_out_type clint_out,
   output logic          timer_irpt,
   output logic          soft_irpt
);

   logic        tick;
   logic        ready;
   logic [31:0] rdata;
   logic        msip;
   logic [63:0] mtime;
   logic [63:0] mtimecmp;
   logic [63:0] mtime_next;
   logic [31:0] rd_val;
   logic        accept;
   logic        wr;
   logic [15:0] offset;
   logic        unused_addr;

   clint_tick #(.RTC_DIV(RTC_DIV)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   assign accept      = clint_in.valid & ~ready;
   assign wr          = accept & (|clint_in.wstrb);
   assign offset      = clint_in.addr[15:0];
   assign unused_addr = ^clint_in.addr[31:16];

   always_comb begin
      rd_val = '0;
      case (offset)
         clint_msip:      rd_val = {31'd0, msip};
         clint_mtimecmp:  rd_val = mtimecmp[31:0];
         clint_mtimecmph: rd_val = mtimecmp[63:32];
         clint_mtime:     rd_val = mtime[31:0];
         clint_mtimeh:    rd_val = mtime[63:32];
         default:         rd_val = '0;
      endcase
   end

   // A bus write to either mtime half replaces that cycle's tick increment.
   always_comb begin
      mtime_next = mtime;
      if (wr && offset == clint_mtime) begin
         mtime_next = {mtime[63:32], merge_bytes(mtime[31:0], clint_in.wdata, clint_in.wstrb)};
      end else if (wr && offset == clint_mtimeh) begin
         mtime_next = {merge_bytes(mtime[63:32], clint_in.wdata, clint_in.wstrb), mtime[31:0]};
      end else if (tick) begin
         mtime_next = mtime + 64'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ready      <= 1'b0;
         rdata      <= '0;
         msip       <= 1'b0;
         mtime      <= '0;
         mtimecmp   <= '1;
         timer_irpt <= 1'b0;
         soft_irpt  <= 1'b0;
      end else begin
         ready      <= accept;
         rdata      <= (accept && !wr) ? rd_val : 32'd0;
         mtime      <= mtime_next;
         timer_irpt <= (mtime >= mtimecmp);
         soft_irpt  <= msip;
         if (wr && offset == clint_msip && clint_in.wstrb[0]) begin
            msip <= clint_in.wdata[0];
         end
         if (wr && offset == clint_mtimecmp) begin
            mtimecmp[31:0] <= merge_bytes(mtimecmp[31:0], clint_in.wdata, clint_in.wstrb);
         end
         if (wr && offset == clint_mtimecmph) begin
            mtimecmp[63:32] <= merge_bytes(mtimecmp[63:32], clint_in.wdata, clint_in.wstrb);
         end
      end
   end

   assign clint_out.rdata = rdata;
   assign clint_out.ready = ready;

endmodule

`default_nettype wire

// File: tb/tb_clint.sv
// Scoreboard bench for clint: two instances (RTC_DIV=4 and RTC_DIV=1) share clk/rst.
`default_nettype none

module tb_clint;
   import clint_pkg::*;

   logic          clk;
   logic          rst;
   clint_in_type  in4, in1;
   clint_out_type out4, out1;
   logic          tirq4, sirq4, tirq1, sirq1;

   int checks = 0;
   int errors = 0;
   logic [31:0] q4[$];
   logic [31:0] q1[$];

   clint #(.RTC_DIV(4)) dut4 (
      .clk(clk), .rst(rst), .clint_in(in4), .clint_out(out4),
      .timer_irpt(tirq4), .soft_irpt(sirq4));

   clint #(.RTC_DIV(1)) dut1 (
      .clk(clk), .rst(rst), .clint_in(in1), .clint_out(out1),
      .timer_irpt(tirq1), .soft_irpt(sirq1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: pops the expected response whenever a DUT presents ready.
   always @(posedge clk) begin
      #1;
      if (out4.ready) begin
         if (q4.size() == 0) begin
            errors++;
            $display("FAIL dut4 unexpected ready: got rdata %h expected no response", out4.rdata);
         end else check("dut4 rdata", 64'(out4.rdata), 64'(q4.pop_front()));
      end else if (out4.rdata != 32'd0) begin
         errors++;
         $display("FAIL dut4 idle rdata: got %h expected 0", out4.rdata);
      end
      if (out1.ready) begin
         if (q1.size() == 0) begin
            errors++;
            $display("FAIL dut1 unexpected ready: got rdata %h expected no response", out1.rdata);
         end else check("dut1 rdata", 64'(out1.rdata), 64'(q1.pop_front()));
      end else if (out1.rdata != 32'd0) begin
         errors++;
         $display("FAIL dut1 idle rdata: got %h expected 0", out1.rdata);
      end
   end

   // Called at a falling edge; accepted at the next rising edge, returns two falling edges later.
   task automatic xact(input int sel, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb, input logic [31:0] exp);
      clint_in_type req;
      req.valid = 1'b1;
      req.addr  = addr;
      req.wdata = wdata;
      req.wstrb = wstrb;
      if (sel == 0) begin
         in4 = req;
         q4.push_back(exp);
      end else begin
         in1 = req;
         q1.push_back(exp);
      end
      @(posedge clk);
      @(negedge clk);
      if (sel == 0) in4.valid = 1'b0;
      else in1.valid = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      int j;
      rst = 1'b0;
      in4 = '0;
      in1 = '0;
      repeat (3) @(negedge clk);
      check("reset ready", 64'(out4.ready), 64'd0);
      check("reset rdata", 64'(out4.rdata), 64'd0);
      check("reset timer_irpt", 64'(tirq4), 64'd0);
      check("reset soft_irpt", 64'(sirq4), 64'd0);
      rst = 1'b1;

      // mtime after k edges is k/4; read i is accepted at edge 41+2i
      repeat (40) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         xact(0, 32'h0000_BFF8, 32'd0, 4'b0000, 32'((40 + 2 * i) / 4));
      end

      xact(0, 32'h0000_4000, 32'd0, 4'b0000, 32'hFFFF_FFFF);
      xact(0, 32'h0000_4004, 32'd0, 4'b0000, 32'hFFFF_FFFF);
      xact(0, 32'h0000_BFFC, 32'd0, 4'b0000, 32'd0);
      check("timer_irpt idle", 64'(tirq4), 64'd0);
      check("soft_irpt idle", 64'(sirq4), 64'd0);

      xact(0, 32'h0000_0000, 32'd1, 4'b1111, 32'd0);
      check("soft_irpt set", 64'(sirq4), 64'd1);
      xact(0, 32'h0000_0000, 32'd0, 4'b0000, 32'd1);
      check("soft_irpt after read", 64'(sirq4), 64'd1);
      xact(0, 32'h0000_0000, 32'd0, 4'b1111, 32'd0);
      check("soft_irpt clear", 64'(sirq4), 64'd0);
      xact(0, 32'h0000_0000, 32'hFFFF_FFFF, 4'b1111, 32'd0);
      xact(0, 32'h0000_0000, 32'd0, 4'b0000, 32'd1);
      xact(0, 32'h0000_0000, 32'd0, 4'b0001, 32'd0);

      xact(0, 32'h0000_4000, 32'h0000_AB00, 4'b0010, 32'd0);
      xact(0, 32'h0200_4000, 32'd0, 4'b0000, 32'hFFFF_ABFF);
      xact(0, 32'h0000_8000, 32'h1234_5678, 4'b1111, 32'd0);
      xact(0, 32'h0000_8000, 32'd0, 4'b0000, 32'd0);
      xact(0, 32'h0000_0004, 32'd0, 4'b0000, 32'd0);

      // Timer compare on the RTC_DIV=1 instance; mtime lo=0 written at edge A
      xact(1, 32'h0000_4004, 32'd0, 4'b1111, 32'd0);
      xact(1, 32'h0000_BFF8, 32'd0, 4'b1111, 32'd0);
      xact(1, 32'h0000_4000, 32'd20, 4'b1111, 32'd0);
      check("timer_irpt below cmp", 64'(tirq1), 64'd0);
      j = 0;
      while (tirq1 == 1'b0 && j < 40) begin
         @(negedge clk);
         j++;
      end
      check("timer_irpt rise cycle", 64'(j), 64'd18);
      xact(1, 32'h0000_BFF8, 32'd0, 4'b0000, 32'd21);
      check("timer_irpt held", 64'(tirq1), 64'd1);
      xact(1, 32'h0000_4000, 32'hFFFF_FFFF, 4'b1111, 32'd0);
      check("timer_irpt fall", 64'(tirq1), 64'd0);

      // mtime wrap with mtimecmp all-ones
      xact(1, 32'h0000_4004, 32'hFFFF_FFFF, 4'b1111, 32'd0);
      xact(1, 32'h0000_BFFC, 32'hFFFF_FFFF, 4'b1111, 32'd0);
      xact(1, 32'h0000_BFF8, 32'hFFFF_FFFF, 4'b1111, 32'd0);
      xact(1, 32'h0000_BFFC, 32'd0, 4'b0000, 32'd0);
      xact(1, 32'h0000_BFF8, 32'd0, 4'b0000, 32'd2);
      check("timer_irpt after wrap", 64'(tirq1), 64'd0);

      // Reset asserted while a request is pending: no response, no update
      in4.valid = 1'b1;
      in4.addr  = 32'h0000_0000;
      in4.wdata = 32'd1;
      in4.wstrb = 4'b0001;
      #2 rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      in4.valid = 1'b0;
      rst = 1'b1;
      xact(0, 32'h0000_4000, 32'd0, 4'b0000, 32'hFFFF_FFFF);
      check("soft_irpt after abort", 64'(sirq4), 64'd0);
      xact(0, 32'h0000_0000, 32'd0, 4'b0000, 32'd0);

      repeat (4) @(negedge clk);
      check("dut4 responses drained", 64'(q4.size()), 64'd0);
      check("dut1 responses drained", 64'(q1.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
